// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs: AXI4-Lite slave exposing NUM_REGS 32-bit R/W registers with byte strobes.
// Rev 1.0 - initial release.
`default_nettype none

module axi4_lite_slave_regs #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] REG_RESET = 32'h0
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [31:0]              AWADDR,
  input  logic [3:0]               AWCACHE,
  input  logic [2:0]               AWPROT,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic [1:0]               BRESP,
  input  logic [31:0]              ARADDR,
  input  logic [3:0]               ARCACHE,
  input  logic [2:0]               ARPROT,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [32*NUM_REGS-1:0]   REGS_OUT,
  output logic [NUM_REGS-1:0]      WR_PULSE
);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam int         c_IDX_W       = 8;

  logic                  aw_held_q;
  logic [31:2]           awaddr_q;
  logic                  w_held_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;
  logic [31:0]           regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [NUM_REGS-1:0]   wr_pulse_d;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [31:2]           w_waddr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_wstrb;
  logic [31:0]           w_bmask;
  logic                  w_wr_in_range;
  logic [c_IDX_W-1:0]    w_wr_idx;
  logic                  w_rd_in_range;
  logic [c_IDX_W-1:0]    w_rd_idx;
  logic [31:0]           w_rd_sel;
  logic                  w_unused;

  // Ready outputs come straight from flops: no VALID-to-READY combinational path.
  assign AWREADY = !aw_held_q && !bvalid_q;
  assign WREADY  = !w_held_q && !bvalid_q;
  assign ARREADY = !rvalid_q;

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;
  assign w_ar_hs = ARVALID && ARREADY;

  assign w_waddr  = aw_held_q ? awaddr_q : AWADDR[31:2];
  assign w_wdata  = w_held_q ? wdata_q : WDATA;
  assign w_wstrb  = w_held_q ? wstrb_q : WSTRB;
  assign w_commit = (aw_held_q || w_aw_hs) && (w_held_q || w_w_hs) && !bvalid_q;

  assign w_bmask = {{8{w_wstrb[3]}}, {8{w_wstrb[2]}}, {8{w_wstrb[1]}}, {8{w_wstrb[0]}}};

  assign w_wr_in_range = (w_waddr < 30'(NUM_REGS));
  assign w_wr_idx      = w_waddr[9:2];
  assign w_rd_in_range = (ARADDR[31:2] < 30'(NUM_REGS));
  assign w_rd_idx      = ARADDR[9:2];

  assign w_unused = ^{AWCACHE, AWPROT, ARCACHE, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  always_comb begin
    wr_pulse_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      wr_pulse_d[k] = w_commit && w_wr_in_range && (w_wr_idx == c_IDX_W'(k));
    end
  end

  always_comb begin
    w_rd_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_rd_idx == c_IDX_W'(k)) begin
        w_rd_sel = regs_q[k];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= c_RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        awaddr_q <= AWADDR[31:2];
      end
      if (w_w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (w_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= w_wr_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
      end else begin
        if (w_aw_hs) aw_held_q <= 1'b1;
        if (w_w_hs)  w_held_q  <= 1'b1;
        if (bvalid_q && BREADY) bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= REG_RESET;
      end
      wr_pulse_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_pulse_d[k]) begin
          regs_q[k] <= (regs_q[k] & ~w_bmask) | (w_wdata & w_bmask);
        end
      end
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Read samples the pre-commit register value when both land on the same edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= c_RESP_OKAY;
    end else if (w_ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= w_rd_in_range ? w_rd_sel : 32'h0;
      rresp_q  <= w_rd_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign WR_PULSE = wr_pulse_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign REGS_OUT[32*k +: 32] = regs_q[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
// tb_axi4_lite_slave_regs: directed stimulus, per-cycle check against a transaction-level model.
`default_nettype none

module tb_axi4_lite_slave_regs;

  localparam int N = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [31:0]   AWADDR = '0;
  logic [3:0]    AWCACHE = '0;
  logic [2:0]    AWPROT = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [31:0]   WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic          BVALID;
  logic          BREADY = 1'b1;
  logic [1:0]    BRESP;
  logic [31:0]   ARADDR = '0;
  logic [3:0]    ARCACHE = '0;
  logic [2:0]    ARPROT = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b1;
  logic [32*N-1:0] REGS_OUT;
  logic [N-1:0]  WR_PULSE;

  int errors = 0;
  int checks = 0;

  axi4_lite_slave_regs #(.NUM_REGS(N), .REG_RESET(32'h0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .REGS_OUT(REGS_OUT), .WR_PULSE(WR_PULSE)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_of(input int k);
    return REGS_OUT[32*k +: 32];
  endfunction

  // Transaction-level model: collect address and data, commit when both are present.
  logic [31:0] m_regs [N];
  bit          m_aw_pend = 0;
  bit          m_w_pend = 0;
  logic [31:0] m_aw_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  bit          m_bvalid = 0;
  logic [1:0]  m_bresp = '0;
  bit          m_rvalid = 0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic [N-1:0] m_pulse = '0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 32'h0;
    m_aw_pend = 0; m_w_pend = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_pulse = '0;
  endtask

  always @(posedge ACLK or negedge ARESETn) begin : p_model
    bit aw_rdy, w_rdy, had_b;
    int idx;
    if (!ARESETn) begin
      model_reset();
    end else begin
      aw_rdy = !m_aw_pend && !m_bvalid;
      w_rdy  = !m_w_pend && !m_bvalid;
      had_b  = m_bvalid;
      if (!m_rvalid && ARVALID) begin
        m_rvalid = 1;
        if (ARADDR < 32'(4 * N)) begin
          idx = int'(ARADDR >> 2);
          m_rdata = m_regs[idx];
          m_rresp = 2'b00;
        end else begin
          m_rdata = 32'h0;
          m_rresp = 2'b10;
        end
      end else if (m_rvalid && RREADY) begin
        m_rvalid = 0;
      end
      m_pulse = '0;
      if (AWVALID && aw_rdy) begin m_aw_pend = 1; m_aw_addr = AWADDR; end
      if (WVALID && w_rdy) begin m_w_pend = 1; m_wdata = WDATA; m_wstrb = WSTRB; end
      if (m_aw_pend && m_w_pend && !had_b) begin
        if (m_aw_addr < 32'(4 * N)) begin
          idx = int'(m_aw_addr >> 2);
          for (int b = 0; b < 4; b++) begin
            if (m_wstrb[b]) m_regs[idx][8*b +: 8] = m_wdata[8*b +: 8];
          end
          m_pulse[idx] = 1'b1;
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
        m_aw_pend = 0; m_w_pend = 0; m_bvalid = 1;
      end else if (had_b && BREADY) begin
        m_bvalid = 0;
      end
    end
  end

  always @(negedge ACLK) begin
    chk("AWREADY", AWREADY, !m_aw_pend && !m_bvalid);
    chk("WREADY", WREADY, !m_w_pend && !m_bvalid);
    chk("ARREADY", ARREADY, !m_rvalid);
    chk("BVALID", BVALID, m_bvalid);
    if (m_bvalid) chk("BRESP", BRESP, m_bresp);
    chk("RVALID", RVALID, m_rvalid);
    if (m_rvalid) begin
      chk("RDATA", RDATA, m_rdata);
      chk("RRESP", RRESP, m_rresp);
    end
    chk("WR_PULSE", WR_PULSE, m_pulse);
    for (int k = 0; k < N; k++) chk($sformatf("REG%0d", k), reg_of(k), m_regs[k]);
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    ARADDR = a; ARVALID = 1;
    tick();
    ARVALID = 0;
  endtask

  initial begin
    repeat (3) tick();
    ARESETn = 1;
    tick();

    // Reset in the middle of a write whose address is already held
    AWADDR = 32'h0; AWVALID = 1;
    tick();
    AWVALID = 0;
    chk("lit_awready_held", AWREADY, 1'b0);
    ARESETn = 0;
    #1;
    chk("lit_awready_in_rst", AWREADY, 1'b1);
    chk("lit_wready_in_rst", WREADY, 1'b1);
    chk("lit_arready_in_rst", ARREADY, 1'b1);
    tick(); tick();
    ARESETn = 1;
    tick();
    for (int k = 0; k < N; k++) chk("lit_reg_after_rst", reg_of(k), 32'h0);
    chk("lit_bvalid_after_rst", BVALID, 1'b0);
    chk("lit_rvalid_after_rst", RVALID, 1'b0);

    // Dropped address: data alone must not commit; a later address to the last register does
    WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1;
    tick();
    WVALID = 0;
    tick();
    chk("lit_no_commit_w_only", BVALID, 1'b0);
    AWADDR = 32'h3C; AWVALID = 1;
    tick();
    AWVALID = 0;
    chk("lit_reg15", reg_of(15), 32'hFFFFFFFF);
    tick();

    // Same-cycle write then read
    wr(32'h08, 32'hDEADBEEF, 4'hF);
    chk("lit_bvalid_wr", BVALID, 1'b1);
    chk("lit_bresp_wr", BRESP, 2'b00);
    chk("lit_pulse2", WR_PULSE, 32'h0004);
    chk("lit_reg2", reg_of(2), 32'hDEADBEEF);
    tick();
    chk("lit_pulse_gone", WR_PULSE, 32'h0);
    chk("lit_bvalid_gone", BVALID, 1'b0);
    rd(32'h08);
    chk("lit_rdata2", RDATA, 32'hDEADBEEF);
    chk("lit_rresp2", RRESP, 2'b00);
    tick();
    chk("lit_rvalid_gone", RVALID, 1'b0);

    // W before AW with a single byte strobe
    wr(32'h04, 32'h11223344, 4'hF);
    tick();
    WDATA = 32'h000000AA; WSTRB = 4'h1; WVALID = 1;
    tick();
    WVALID = 0;
    chk("lit_wready_held", WREADY, 1'b0);
    chk("lit_awready_free", AWREADY, 1'b1);
    repeat (3) tick();
    BREADY = 0;
    AWADDR = 32'h04; AWVALID = 1;
    tick();
    AWVALID = 0;
    chk("lit_reg1_merge", reg_of(1), 32'h112233AA);
    chk("lit_awready_b", AWREADY, 1'b0);
    tick();
    chk("lit_wready_b", WREADY, 1'b0);
    BREADY = 1;
    tick();
    chk("lit_awready_back", AWREADY, 1'b1);

    // AW before W, upper-half strobe
    AWADDR = 32'h14; AWVALID = 1;
    tick();
    AWVALID = 0;
    tick();
    WDATA = 32'hCAFEF00D; WSTRB = 4'b1100; WVALID = 1;
    tick();
    WVALID = 0;
    chk("lit_reg5", reg_of(5), 32'hCAFE0000);
    tick();

    // Zero strobe still pulses
    wr(32'h10, 32'hFFFFFFFF, 4'h0);
    chk("lit_pulse4", WR_PULSE, 32'h0010);
    chk("lit_reg4_kept", reg_of(4), 32'h0);
    tick();

    // Out of range, including high address bits
    wr(32'h40, 32'h12345678, 4'hF);
    chk("lit_bresp_oor", BRESP, 2'b10);
    chk("lit_pulse_oor", WR_PULSE, 32'h0);
    tick();
    rd(32'h44);
    chk("lit_rdata_oor", RDATA, 32'h0);
    chk("lit_rresp_oor", RRESP, 2'b10);
    tick();
    wr(32'h1000_0004, 32'h55555555, 4'hF);
    chk("lit_bresp_hi", BRESP, 2'b10);
    chk("lit_reg1_untouched", reg_of(1), 32'h112233AA);
    tick();
    rd(32'h8000_0008);
    chk("lit_rresp_hi", RRESP, 2'b10);
    tick();

    // Backpressure on both response channels with new requests waiting
    BREADY = 0; RREADY = 0;
    AWADDR = 32'h18; WDATA = 32'h0BADF00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 32'h08; ARVALID = 1;
    tick();
    AWADDR = 32'h1C; WDATA = 32'h00000077; ARADDR = 32'h04;
    repeat (5) begin
      tick();
      chk("lit_bp_bvalid", BVALID, 1'b1);
      chk("lit_bp_rdata", RDATA, 32'hDEADBEEF);
      chk("lit_bp_arready", ARREADY, 1'b0);
      chk("lit_bp_awready", AWREADY, 1'b0);
    end
    BREADY = 1; RREADY = 1;
    tick();
    chk("lit_bp_arready_back", ARREADY, 1'b1);
    tick();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    chk("lit_reg7", reg_of(7), 32'h00000077);
    chk("lit_rdata_after_bp", RDATA, 32'h112233AA);
    tick();

    // Read and commit on the same edge
    wr(32'h0C, 32'h9, 4'hF);
    tick();
    AWADDR = 32'h0C; WDATA = 32'h5; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 32'h0C; ARVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    chk("lit_collide_old", RDATA, 32'h9);
    chk("lit_collide_reg", reg_of(3), 32'h5);
    tick();
    rd(32'h0C);
    chk("lit_collide_new", RDATA, 32'h5);
    tick();

    // Back-to-back reads with ARVALID held
    ARADDR = 32'h14; ARVALID = 1;
    repeat (4) tick();
    ARVALID = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
